// File: rtl/rom_header_probe_if.sv
// Byte-read handshake between the header probe and the image store.
//   rd_req  : master -> slave, held until rd_ack or the master gives up
//   rd_addr : master -> slave, linear image byte address, stable while rd_req=1
//   rd_ack  : slave -> master, read complete; rd_data valid in the same cycle
//   rd_data : slave -> master, read byte
interface rom_header_probe_if;
    logic        rd_req;
    logic [21:0] rd_addr;
    logic        rd_ack;
    logic [7:0]  rd_data;

    modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
    modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/rom_header_probe.sv
// SNES cartridge header probe. Reads the LoROM ($7FC0) and HiROM ($FFC0)
// header candidates, scores both and reports the chosen mapping.
//   clk, resetn  : clock, asynchronous active-low reset
//   start        : 1-cycle pulse, begins a probe (ignored while busy)
//   bus          : byte-read handshake (master side)
//   busy, done   : probe in progress / 1-cycle results-valid pulse
//   is_hirom, fastrom, rom_size, reset_vec : chosen candidate's fields
//   score_lo, score_hi : candidate scores (0..9)
//   timeout_err  : some read in the last probe timed out and read as $00
module rom_header_probe #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    rom_header_probe_if.master      bus,
    output logic                    busy,
    output logic                    done,
    output logic                    is_hirom,
    output logic                    fastrom,
    output logic [3:0]              rom_size,
    output logic [15:0]             reset_vec,
    output logic [3:0]              score_lo,
    output logic [3:0]              score_hi,
    output logic                    timeout_err
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_NEXT, S_SCORE, S_DONE} state_t;

    state_t      state;
    logic [7:0]  hdr [18];   // 0..8 LoROM, 9..17 HiROM, in read order
    logic [4:0]  idx;
    logic [CW-1:0] wcnt;
    logic        req_q;
    logic [21:0] addr_q;
    logic [3:0]  sl, sh;

    assign bus.rd_req  = req_q;
    assign bus.rd_addr = addr_q;

    // Read order per candidate: $15 map, $16 type, $17 size, $1C/$1D complement,
    // $1E/$1F checksum, $3C/$3D reset vector.
    function automatic logic [21:0] addr_of(input logic [4:0] i);
        logic [4:0]  k;
        logic [5:0]  off;
        logic [21:0] base;
        if (i >= 5'd9) begin
            k    = i - 5'd9;
            base = 22'h00FFC0;
        end else begin
            k    = i;
            base = 22'h007FC0;
        end
        case (k)
            5'd0:    off = 6'h15;
            5'd1:    off = 6'h16;
            5'd2:    off = 6'h17;
            5'd3:    off = 6'h1C;
            5'd4:    off = 6'h1D;
            5'd5:    off = 6'h1E;
            5'd6:    off = 6'h1F;
            5'd7:    off = 6'h3C;
            default: off = 6'h3D;
        endcase
        return base + {16'd0, off};
    endfunction

    function automatic logic [3:0] score_of(
        input logic [7:0] map, input logic [7:0] size,
        input logic [7:0] c_lo, input logic [7:0] c_hi,
        input logic [7:0] k_lo, input logic [7:0] k_hi,
        input logic [7:0] v_hi, input logic hirom);
        logic [3:0] s;
        s = '0;
        if (({c_hi, c_lo} ^ {k_hi, k_lo}) == 16'hFFFF) s = s + 4'd4;
        if (map[7:5] == 3'b001 && map[0] == hirom)     s = s + 4'd2;
        if (v_hi[7])                                    s = s + 4'd2;
        if (size >= 8'h08 && size <= 8'h0D)             s = s + 4'd1;
        return s;
    endfunction

    always_comb begin
        sl = score_of(hdr[0], hdr[2], hdr[3], hdr[4], hdr[5], hdr[6], hdr[8], 1'b0);
        sh = score_of(hdr[9], hdr[11], hdr[12], hdr[13], hdr[14], hdr[15], hdr[17], 1'b1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            for (int unsigned i = 0; i < 18; i++) hdr[i] <= '0;
            idx         <= '0;
            wcnt        <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            is_hirom    <= 1'b0;
            fastrom     <= 1'b0;
            rom_size    <= '0;
            reset_vec   <= '0;
            score_lo    <= '0;
            score_hi    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_REQ;
                        idx         <= '0;
                        wcnt        <= '0;
                        req_q       <= 1'b1;
                        addr_q      <= addr_of(5'd0);
                        busy        <= 1'b1;
                        is_hirom    <= 1'b0;
                        fastrom     <= 1'b0;
                        rom_size    <= '0;
                        reset_vec   <= '0;
                        score_lo    <= '0;
                        score_hi    <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (bus.rd_ack) begin
                        hdr[idx] <= bus.rd_data;
                        req_q    <= 1'b0;
                        state    <= S_NEXT;
                    end else if (wcnt == CW'(TIMEOUT - 1)) begin
                        // Unanswered read: substitute $00 so the probe still completes.
                        hdr[idx]    <= 8'h00;
                        timeout_err <= 1'b1;
                        req_q       <= 1'b0;
                        state       <= S_NEXT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (idx == 5'd17) begin
                        state <= S_SCORE;
                    end else begin
                        idx    <= idx + 5'd1;
                        addr_q <= addr_of(idx + 5'd1);
                        wcnt   <= '0;
                        req_q  <= 1'b1;
                        state  <= S_REQ;
                    end
                end
                S_SCORE: begin
                    score_lo <= sl;
                    score_hi <= sh;
                    if (sh > sl) begin
                        is_hirom  <= 1'b1;
                        fastrom   <= hdr[9][4];
                        rom_size  <= hdr[11][3:0];
                        reset_vec <= {hdr[17], hdr[16]};
                    end else begin
                        is_hirom  <= 1'b0;
                        fastrom   <= hdr[0][4];
                        rom_size  <= hdr[2][3:0];
                        reset_vec <= {hdr[8], hdr[7]};
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_header_probe.sv
// Directed self-checking bench for rom_header_probe: image store responder with
// zero/random ack latency and an optional never-acked address.
module tb_rom_header_probe;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, is_hirom, fastrom, timeout_err;
    logic [3:0]  rom_size, score_lo, score_hi;
    logic [15:0] reset_vec;

    int checks = 0;
    int errors = 0;

    rom_header_probe_if bus ();

    rom_header_probe #(.TIMEOUT(64)) dut (
        .clk(clk), .resetn(resetn), .start(start), .bus(bus),
        .busy(busy), .done(done), .is_hirom(is_hirom), .fastrom(fastrom),
        .rom_size(rom_size), .reset_vec(reset_vec), .score_lo(score_lo),
        .score_hi(score_hi), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Image store and responder
    logic [7:0] mem [0:65535];
    bit         rand_mode = 1'b0;
    bit         hang_en = 1'b0;
    logic       ack_q = 1'b0;
    logic [7:0] data_q = 8'h00;
    int         wait_c = 0;
    int         tgt = 3;

    assign bus.rd_ack  = rand_mode ? ack_q
                                   : (bus.rd_req && !(hang_en && bus.rd_addr == 22'h00FFDC));
    assign bus.rd_data = rand_mode ? data_q : mem[bus.rd_addr[15:0]];

    always @(posedge clk) begin
        if (!rand_mode) begin
            ack_q  <= 1'b0;
            wait_c <= 0;
        end else if (ack_q) begin
            ack_q <= 1'b0;
        end else if (bus.rd_req) begin
            if (wait_c >= tgt) begin
                ack_q  <= 1'b1;
                data_q <= mem[bus.rd_addr[15:0]];
                wait_c <= 0;
                tgt    <= $urandom_range(0, 19);
            end else begin
                wait_c <= wait_c + 1;
            end
        end
    end

    // Monitors: address stability during a request and cycles spent on $FFDC
    int          unstable = 0;
    int          hang_cycles = 0;
    logic        prev_req = 1'b0;
    logic [21:0] prev_addr = '0;
    always @(negedge clk) begin
        if (bus.rd_req && prev_req && bus.rd_addr != prev_addr) unstable++;
        if (bus.rd_req && bus.rd_addr == 22'h00FFDC) hang_cycles++;
        prev_req  = bus.rd_req;
        prev_addr = bus.rd_addr;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic put_hdr(input int base, input logic [7:0] map, input logic [7:0] size,
                           input logic [15:0] cmp, input logic [15:0] ck, input logic [15:0] vec);
        mem[base + 'h15] = map;
        mem[base + 'h17] = size;
        mem[base + 'h1C] = cmp[7:0];
        mem[base + 'h1D] = cmp[15:8];
        mem[base + 'h1E] = ck[7:0];
        mem[base + 'h1F] = ck[15:8];
        mem[base + 'h3C] = vec[7:0];
        mem[base + 'h3D] = vec[15:8];
    endtask

    // Pulses start in cycle 0, observes cycles 1..maxc; optional second start pulse.
    task automatic run_probe(input int maxc, input int restart_at,
                             output int done_cyc, output int ndone);
        done_cyc = -1;
        ndone    = 0;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_results(input string t, input logic h, input logic f,
                                 input logic [3:0] sz, input logic [15:0] v,
                                 input logic [3:0] sl, input logic [3:0] sh, input logic te);
        check({t, "_is_hirom"}, is_hirom, h);
        check({t, "_fastrom"}, fastrom, f);
        check({t, "_rom_size"}, rom_size, sz);
        check({t, "_reset_vec"}, reset_vec, v);
        check({t, "_score_lo"}, score_lo, sl);
        check({t, "_score_hi"}, score_hi, sh);
        check({t, "_timeout_err"}, timeout_err, te);
    endtask

    function automatic logic [55:0] all_outs();
        return {busy, done, is_hirom, fastrom, rom_size, reset_vec, score_lo, score_hi,
                timeout_err, bus.rd_req, bus.rd_addr};
    endfunction

    initial begin
        int dc, nd, cnt;
        clear_mem();
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 56'h0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_outputs", all_outs(), 56'h0);

        // 1: LoROM image, zero latency, exact done cycle
        put_hdr('h7FC0, 8'h20, 8'h09, 16'h1234, 16'hEDCB, 16'h8000);
        run_probe(45, 0, dc, nd);
        check("t1_done_cycle", dc, 38);
        check("t1_done_count", nd, 1);
        check("t1_busy_after", busy, 1'b0);
        check_results("t1", 1'b0, 1'b0, 4'h9, 16'h8000, 4'd9, 4'd0, 1'b0);

        // 2: HiROM FastROM image
        clear_mem();
        put_hdr('hFFC0, 8'h31, 8'h0C, 16'h1234, 16'hEDCB, 16'h8000);
        run_probe(45, 0, dc, nd);
        check("t2_done_cycle", dc, 38);
        check_results("t2", 1'b1, 1'b1, 4'hC, 16'h8000, 4'd0, 4'd9, 1'b0);

        // 4b: same image, random latency 1..20
        rand_mode = 1'b1;
        unstable  = 0;
        run_probe(600, 0, dc, nd);
        rand_mode = 1'b0;
        check("t4_rand_done_count", nd, 1);
        check("t4_addr_stable", unstable, 0);
        check_results("t4", 1'b1, 1'b1, 4'hC, 16'h8000, 4'd0, 4'd9, 1'b0);

        // 3a: identical map $20 at both bases -> 9 vs 7
        clear_mem();
        put_hdr('h7FC0, 8'h20, 8'h0A, 16'h1234, 16'hEDCB, 16'h8123);
        put_hdr('hFFC0, 8'h20, 8'h0C, 16'h1234, 16'hEDCB, 16'hC000);
        run_probe(45, 0, dc, nd);
        check_results("t3a", 1'b0, 1'b0, 4'hA, 16'h8123, 4'd9, 4'd7, 1'b0);

        // 3b: HiROM map $31 -> tie at 9 chooses LoROM
        put_hdr('hFFC0, 8'h31, 8'h0C, 16'h1234, 16'hEDCB, 16'hC000);
        run_probe(45, 0, dc, nd);
        check_results("t3b", 1'b0, 1'b0, 4'hA, 16'h8123, 4'd9, 4'd9, 1'b0);

        // 5: $FFDC never acked -> $00 after 64 cycles, checksum fails
        clear_mem();
        put_hdr('hFFC0, 8'h31, 8'h0C, 16'h1234, 16'hEDCB, 16'h8000);
        hang_en     = 1'b1;
        hang_cycles = 0;
        run_probe(120, 0, dc, nd);
        hang_en = 1'b0;
        check("t5_done_cycle", dc, 101);
        check("t5_hang_cycles", hang_cycles, 64);
        check_results("t5", 1'b1, 1'b1, 4'hC, 16'h8000, 4'd0, 4'd5, 1'b1);

        // 6a: reset during byte 10 ($FFD6) -> outputs clear at once, no done
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cnt = 0;
        while (!(bus.rd_req && bus.rd_addr == 22'h00FFD6) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("t6_reached_byte10", bus.rd_addr, 22'h00FFD6);
        #1 resetn = 1'b0;
        #1 check("t6_reset_outputs", all_outs(), 56'h0);
        nd = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        resetn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("t6_no_done_after_abort", nd, 0);
        check("t6_idle_after_abort", all_outs(), 56'h0);

        // 6b: extra start while busy is ignored
        clear_mem();
        put_hdr('h7FC0, 8'h20, 8'h09, 16'h1234, 16'hEDCB, 16'h8000);
        run_probe(80, 5, dc, nd);
        check("t6_single_done", nd, 1);
        check("t6_done_cycle", dc, 38);
        check_results("t6", 1'b0, 1'b0, 4'h9, 16'h8000, 4'd9, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
